// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory responder: state encoding and
// the width helper for the wait-cycle counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    // Counter must hold 0..MEM_LAT; a 1-bit minimum keeps degenerate widths legal.
    function automatic int cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Access-length counter: cleared while idle, counts every access cycle and
// flags the last cycle (count == MEM_LAT-1) of the current access.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int CW = cnt_w(MEM_LAT);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    logic [CW-1:0] count_q;

    // NOTE: reset is synchronous, so it is simply the first branch inside the clocked block.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign done_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Unified-memory responder: serialises IF fetches and MEM-stage loads/stores
// onto one memory port, with MEM_LAT wait cycles and one-cycle ack pulses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              busy
);

    arb_state_e        state_q;
    logic [1:0]        data_streak_q;
    logic              if_ack_q, d_ack_q, mem_we_q, mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic              grant_d, grant_i, cnt_done;

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q != IDLE),
        .done_o   (cnt_done)
    );

    // Data normally wins (its instruction is older); after two data grants in a row a
    // waiting fetch gets the port so IF cannot be starved by back-to-back loads/stores.
    assign grant_d = d_req && !((data_streak_q == 2'd2) && if_req);
    assign grant_i = if_req && !grant_d;

    // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            data_streak_q <= 2'd0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= DATA;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_we_q    <= d_we;
                        mem_re_q    <= !d_we;
                        if (data_streak_q != 2'd2) begin
                            data_streak_q <= data_streak_q + 2'd1;
                        end
                    end else if (grant_i) begin
                        state_q       <= INSTR;
                        mem_addr_q    <= if_addr;
                        mem_re_q      <= 1'b1;
                        data_streak_q <= 2'd0;
                    end
                end
                INSTR: begin
                    if (cnt_done) begin
                        if_rdata_q <= mem_rdata;
                        if_ack_q   <= 1'b1;
                        mem_re_q   <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_ack_q  <= 1'b1;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign stall_if  = if_req && !if_ack_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected acks plus
// directed timing checks for fetch, collision, store, starvation and reset.
module tb_mem_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              busy;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acks = 0;
    int          cyc = 0;
    int          last_d_cyc = 0;
    int          last_if_cyc = 0;
    bit          d_hold = 1'b0;
    logic [31:0] mem_model [0:255];

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    assign mem_rdata = mem_re ? mem_model[mem_addr[9:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic expect_ack(input bit is_data, input logic [31:0] data);
        exp_t e;
        e.is_data = is_data;
        e.data    = data;
        sb_q.push_back(e);
    endtask

    task automatic score(input bit is_data, input logic [31:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            check(is_data ? "unexpected_d_ack" : "unexpected_if_ack", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check(is_data ? "d_ack_order" : "if_ack_order", 32'(is_data), 32'(e.is_data));
        check(is_data ? "d_rdata" : "if_rdata", data, e.data);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k = 0;
        while (n_acks < target && k < budget) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("ack_timeout", 32'(n_acks >= target), 32'd1);
    endtask

    // Requester model: each side drops its request in the ack cycle, unless held on purpose.
    always @(negedge clock) begin
        if (if_ack || d_ack) begin
            check("ack_exclusive", 32'(if_ack && d_ack), 32'd0);
            n_acks++;
        end
        if (d_ack) begin
            if (if_req) check("stall_during_d_ack", 32'(stall_if), 32'd1);
            score(1'b1, d_rdata);
            last_d_cyc = cyc;
            if (!d_hold) begin
                d_req = 1'b0;
                d_we  = 1'b0;
            end
        end
        if (if_ack) begin
            score(1'b0, if_rdata);
            last_if_cyc = cyc;
            if_req = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, we_cnt;
        bit re_seen;
        logic [31:0] we_addr, we_data;

        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[8'h04] = 32'h2008_0005;
        mem_model[8'h40] = 32'hDEAD_BEEF;

        // Reset held for three cycles
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we_re", {30'd0, mem_we, mem_re}, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall_if", 32'(stall_if), 32'd0);
        tick();
        reset_n = 1'b1;

        // Single fetch: ack three cycles after the request
        tick();
        base = n_acks;
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        expect_ack(1'b0, 32'h2008_0005);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("t2_stall_if", 32'(stall_if), 32'(c < 3));
            check("t2_if_ack", 32'(if_ack), 32'(c == 3));
            check("t2_busy", 32'(busy), 32'(c == 1 || c == 2));
            check("t2_mem_re", 32'(mem_re), 32'(c == 1 || c == 2));
            if (c == 1) check("t2_mem_addr", mem_addr, 32'h0000_0010);
        end
        wait_acks(base + 1, 5);

        // Collision: data first, fetch MEM_LAT+1 cycles later
        tick();
        base = n_acks;
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0100;
        expect_ack(1'b1, 32'hDEAD_BEEF);
        expect_ack(1'b0, 32'h2008_0005);
        wait_acks(base + 2, 20);
        check("t3_ack_spacing", 32'(last_if_cyc - last_d_cyc), 32'(MEM_LAT + 1));

        // Store: write strobe for MEM_LAT cycles, no read, load data untouched
        tick();
        base    = n_acks;
        we_cnt  = 0;
        re_seen = 1'b0;
        we_addr = '0;
        we_data = '0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = 32'h1234_5678;
        expect_ack(1'b1, 32'hDEAD_BEEF);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (mem_re) re_seen = 1'b1;
        end
        wait_acks(base + 1, 5);
        check("t4_we_cycles", 32'(we_cnt), 32'(MEM_LAT));
        check("t4_mem_addr", we_addr, 32'h0000_0040);
        check("t4_mem_wdata", we_data, 32'h1234_5678);
        check("t4_no_read", 32'(re_seen), 32'd0);

        // Starvation guard: held data requests let a fetch through every third grant
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        base    = n_acks;
        d_hold  = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0100;
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        expect_ack(1'b1, 32'hDEAD_BEEF);
        expect_ack(1'b1, 32'hDEAD_BEEF);
        expect_ack(1'b0, 32'h2008_0005);
        expect_ack(1'b1, 32'hDEAD_BEEF);
        wait_acks(base + 3, 30);
        d_hold = 1'b0;
        wait_acks(base + 4, 10);
        repeat (6) tick();
        check("t5_no_extra_acks", 32'(n_acks), 32'(base + 4));
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during the second access cycle aborts the fetch
        tick();
        base    = n_acks;
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        tick();
        tick();
        reset_n = 1'b0;
        if_req  = 1'b0;
        @(negedge clock);
        check("t6_mem_re_before", 32'(mem_re), 32'd1);
        tick();
        @(negedge clock);
        check("t6_mem_re_after", 32'(mem_re), 32'd0);
        check("t6_mem_we_after", 32'(mem_we), 32'd0);
        check("t6_busy_after", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("t6_no_ack", 32'(n_acks), 32'(base));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
